// File: rtl/debug_ocimem_pkg.sv
// Shared types and jdo field positions for the debug monitor RAM controller.
package debug_ocimem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DBG_RD,
        DBG_WR,
        CPU_RD
    } state_t;

    localparam int JDO_RD         = 35;
    localparam int JDO_ADDR_LSB   = 17;
    localparam int JDO_WDATA_LSB  = 3;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/debug_ocimem_ram.sv
// Single-port monitor RAM with byte lanes and one cycle of read latency.
module debug_ocimem_ram
    import debug_ocimem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = 8
) (
    input  logic                      clk,
    input  logic                      i_we,
    input  logic [BYTES_PER_WORD-1:0] i_be,
    input  logic [AW-1:0]             i_addr,
    input  logic [31:0]               i_wdata,
    output logic [31:0]               o_q
);

    logic [31:0] r_mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < BYTES_PER_WORD; b++) begin
                if (i_be[b]) begin
                    r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
        o_q <= r_mem[i_addr];
    end

endmodule

// File: rtl/debug_ocimem_ctrl.sv
// Debugger and CPU access arbiter for the on-chip debug monitor RAM.
// Debug commands always win; the CPU is stalled until the FSM is back in IDLE.
module debug_ocimem_ctrl
    import debug_ocimem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [37:0]   jdo,
    input  logic          take_action_ocimem_a,
    input  logic          take_no_action_ocimem_a,
    input  logic          take_action_ocimem_b,
    output logic [31:0]   MonDReg,
    output logic [AW+1:0] MonAReg,
    output logic          monitor_ready,
    output logic          monitor_error,
    input  logic [AW-1:0] avs_address,
    input  logic          avs_read,
    input  logic          avs_write,
    input  logic [31:0]   avs_writedata,
    input  logic [3:0]    avs_byteenable,
    output logic [31:0]   avs_readdata,
    output logic          avs_waitrequest
);

    state_t                    r_state;
    logic                      r_rdCapture;
    logic                      r_readyPend;
    logic [31:0]               r_readHold;

    logic                      w_dbgStrobe;
    logic [AW-1:0]             w_monWord;
    logic [AW-1:0]             w_nextWord;
    logic [AW-1:0]             w_ramAddr;
    logic                      w_ramWe;
    logic                      w_ramWeGated;
    logic [BYTES_PER_WORD-1:0] w_ramBe;
    logic [31:0]               w_ramWdata;
    logic [31:0]               w_ramQ;
    logic                      w_cpuComplete;
    logic                      w_unusedJdo;

    assign w_dbgStrobe  = take_action_ocimem_a | take_action_ocimem_b
                        | (take_no_action_ocimem_a & jdo[JDO_RD]);
    assign w_monWord    = MonAReg[AW+1:2];
    assign w_nextWord   = w_monWord + AW'(1);
    assign w_ramWeGated = w_ramWe & reset_n;
    assign w_unusedJdo  = ^{jdo[37:36], jdo[2:0]};

    always_comb begin
        w_ramAddr     = avs_address;
        w_ramWe       = 1'b0;
        w_ramBe       = avs_byteenable;
        w_ramWdata    = avs_writedata;
        w_cpuComplete = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_dbgStrobe && !avs_read && avs_write) begin
                    w_ramWe       = 1'b1;
                    w_cpuComplete = 1'b1;
                end
            end
            DBG_RD: w_ramAddr = w_monWord;
            DBG_WR: begin
                w_ramAddr  = w_monWord;
                w_ramWe    = 1'b1;
                w_ramBe    = '1;
                w_ramWdata = MonDReg;
            end
            CPU_RD: w_cpuComplete = 1'b1;
            default: ;
        endcase
    end

    assign avs_waitrequest = (avs_read | avs_write) & ~w_cpuComplete;
    assign avs_readdata    = (r_state == CPU_RD) ? w_ramQ : r_readHold;

    // DBG_RD spends one cycle issuing the read and one capturing ram_q
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_rdCapture   <= 1'b0;
            r_readyPend   <= 1'b0;
            r_readHold    <= '0;
            MonDReg       <= '0;
            MonAReg       <= '0;
            monitor_ready <= 1'b0;
            monitor_error <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (r_readyPend) begin
                        monitor_ready <= 1'b1;
                        r_readyPend   <= 1'b0;
                    end
                    if (take_action_ocimem_a) begin
                        MonAReg       <= {jdo[JDO_ADDR_LSB+2 +: AW], 2'b00};
                        monitor_ready <= 1'b0;
                        monitor_error <= 1'b0;
                        if (jdo[JDO_RD]) begin
                            r_state     <= DBG_RD;
                            r_rdCapture <= 1'b0;
                            r_readyPend <= 1'b0;
                        end else begin
                            r_readyPend <= 1'b1;
                        end
                    end else if (take_no_action_ocimem_a && jdo[JDO_RD]) begin
                        monitor_ready <= 1'b0;
                        r_readyPend   <= 1'b0;
                        r_rdCapture   <= 1'b0;
                        r_state       <= DBG_RD;
                    end else if (take_action_ocimem_b) begin
                        MonDReg       <= jdo[JDO_WDATA_LSB +: 32];
                        monitor_ready <= 1'b0;
                        r_readyPend   <= 1'b0;
                        r_state       <= DBG_WR;
                    end else if (avs_read) begin
                        r_state <= CPU_RD;
                    end
                end
                DBG_RD: begin
                    if (!r_rdCapture) begin
                        r_rdCapture <= 1'b1;
                    end else begin
                        r_rdCapture   <= 1'b0;
                        MonDReg       <= w_ramQ;
                        monitor_ready <= 1'b1;
                        MonAReg       <= {w_nextWord, 2'b00};
                        r_state       <= IDLE;
                    end
                end
                DBG_WR: begin
                    monitor_ready <= 1'b1;
                    MonAReg       <= {w_nextWord, 2'b00};
                    r_state       <= IDLE;
                end
                CPU_RD: begin
                    r_readHold <= w_ramQ;
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
            if (r_state != IDLE && w_dbgStrobe) begin
                monitor_error <= 1'b1;
            end
        end
    end

    debug_ocimem_ram #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_ram (
        .clk    (clk),
        .i_we   (w_ramWeGated),
        .i_be   (w_ramBe),
        .i_addr (w_ramAddr),
        .i_wdata(w_ramWdata),
        .o_q    (w_ramQ)
    );

endmodule
